// File: rtl/mul4_rr_scheduler.sv
// Round-robin scheduler sharing one 4x4 unsigned array multiplier among up to
// four requesters. Operands are registered before the multiplier and the
// product is registered after it, so the multiplier ripple path sits alone
// between two flop stages.
module mul4_rr_scheduler #(
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [1:0]        rsp_id,
  output logic [7:0]        rsp_prod,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [1:0]  id_q, id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_prod_q, rsp_prod_d;

  // Inputs padded to the full four-requester width; padding bits are zero so
  // indices >= NREQ can never win.
  logic [3:0]  valid_pad;
  logic [15:0] req_a_pad;
  logic [15:0] req_b_pad;
  logic [3:0]  ready_pad;

  logic        found;
  logic [1:0]  grant_idx;
  logic [2:0]  pos;
  logic [3:0]  a_sel;
  logic [3:0]  b_sel;
  logic [7:0]  mul_prod;

  assign valid_pad = 4'(req_valid);
  assign req_a_pad = 16'(req_a);
  assign req_b_pad = 16'(req_b);
  assign a_sel     = req_a_pad[{grant_idx, 2'b00} +: 4];
  assign b_sel     = req_b_pad[{grant_idx, 2'b00} +: 4];

  // Round-robin search: first valid index starting at ptr, wrapping at NREQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = 2'd0;
    pos       = 3'd0;
    for (int unsigned k = 0; k < 4; k++) begin
      pos = {1'b0, ptr_q} + 3'(k);
      if (pos >= 3'(NREQ)) pos = pos - 3'(NREQ);
      if (k < NREQ && !found && valid_pad[pos[1:0]]) begin
        found     = 1'b1;
        grant_idx = pos[1:0];
      end
    end
  end

  // One-hot accept, only in IDLE and never while reset is asserted.
  always_comb begin
    ready_pad = 4'd0;
    if (state_q == StIdle && found && !rst) ready_pad[grant_idx] = 1'b1;
    req_ready = ready_pad[NREQ-1:0];
  end

  // Shift-and-add array multiplier on the registered operands.
  always_comb begin
    mul_prod = 8'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b_q[i]) mul_prod = mul_prod + (8'(a_q) << i);
    end
  end

  // Next-state logic for the IDLE -> MUL -> HOLD transaction sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = grant_idx;
          ptr_d   = (grant_idx == 2'(NREQ - 1)) ? 2'd0 : grant_idx + 2'd1;
          state_d = StMul;
        end
      end
      StMul: begin
        rsp_prod_d  = mul_prod;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      id_q        <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_prod_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;

endmodule

// File: tb/tb_mul4_rr_scheduler.sv
// Self-checking bench for mul4_rr_scheduler with a round-robin reference model.
module tb_mul4_rr_scheduler;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_prod;
  logic        rsp_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mptr   = 0;  // model round-robin pointer

  mul4_rr_scheduler #(.NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: first valid index at ptr, ptr+1, ... modulo N.
  function automatic int rr_pick(input int ptr, input logic [3:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] ref_prod(input logic [15:0] av, input logic [15:0] bv,
                                          input int g);
    int a;
    int b;
    a = int'(av[4*g +: 4]);
    b = int'(bv[4*g +: 4]);
    return 8'(a * b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'd0;
    rsp_ready = 1'b0;
    tick();
    rst  = 1'b0;
    mptr = 0;
  endtask

  // Drives one transaction and reports what the DUT did; no comparisons here.
  task automatic issue(input logic [3:0] mask, input logic [15:0] av, input logic [15:0] bv,
                       input int hold, output logic [3:0] grant, output int wcyc,
                       output int gcyc, output int lat, output logic [1:0] id,
                       output logic [7:0] prod, output logic quiet);
    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    rsp_ready = 1'b0;
    quiet     = 1'b1;
    lat       = 0;
    id        = 2'd0;
    prod      = 8'd0;
    #1;
    wcyc = 0;
    while (req_ready == 4'd0 && wcyc < 20) begin
      tick();
      wcyc++;
    end
    grant = req_ready;
    gcyc  = cyc;
    if (grant == 4'd0) return;
    tick();
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (req_ready !== 4'd0) quiet = 1'b0;
      tick();
      lat++;
    end
    id   = rsp_id;
    prod = rsp_prod;
    if (req_ready !== 4'd0) quiet = 1'b0;
    repeat (hold) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_prod !== prod || req_ready !== 4'd0)
        quiet = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = 16'h1234;
    req_b     = 16'h5678;
    rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'd0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_prod !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b id=%0d prod=%h, want 0000 0 0 00",
               req_ready, rsp_valid, rsp_id, rsp_prod);
    end
    rst       = 1'b0;
    req_valid = 4'd0;
    mptr      = 0;
  endtask

  task automatic test_single();
    logic [3:0] g;
    int w, gc, lat;
    logic [1:0] id;
    logic [7:0] p;
    logic q;
    issue(4'b0001, 16'h0003, 16'h0005, 0, g, w, gc, lat, id, p, q);
    mptr = 1;
    checks++;
    if (g !== 4'b0001 || w != 0) begin
      errors++;
      $display("FAIL single_grant: got grant=%b wait=%0d, want 0001 wait=0", g, w);
    end
    checks++;
    if (lat != 2 || id !== 2'd0 || p !== 8'h0F || !q) begin
      errors++;
      $display("FAIL single_rsp: got lat=%0d id=%0d prod=%h quiet=%b, want 2 0 0f 1",
               lat, id, p, q);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after_hs: got rsp_valid=%b, want 0", rsp_valid);
    end
    req_valid = 4'd0;
  endtask

  task automatic test_corners();
    logic [7:0] ops [4];
    logic [3:0] g;
    int w, gc, lat;
    logic [1:0] id;
    logic [7:0] p, exp;
    logic q;
    ops[0] = 8'hFF; ops[1] = 8'h09; ops[2] = 8'hF1; ops[3] = 8'h82;
    for (int k = 0; k < 4; k++) begin
      exp = 8'(int'(ops[k][7:4]) * int'(ops[k][3:0]));
      issue(4'b0010, {8'h00, ops[k][7:4], 4'h0}, {8'h00, ops[k][3:0], 4'h0}, 1,
            g, w, gc, lat, id, p, q);
      mptr = 2;
      checks++;
      if (g !== 4'b0010 || id !== 2'd1 || p !== exp || lat != 2) begin
        errors++;
        $display("FAIL corner_%0d: got grant=%b id=%0d prod=%h lat=%0d, want 0010 1 %h 2",
                 k, g, id, p, lat, exp);
      end
    end
    req_valid = 4'd0;
  endtask

  task automatic test_fairness();
    logic [3:0] g;
    int w, gc, lat, prev, eg;
    logic [1:0] id;
    logic [7:0] p;
    logic q;
    do_reset();
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      eg = rr_pick(mptr, 4'hF);
      issue(4'hF, 16'h5432, 16'h9631, 0, g, w, gc, lat, id, p, q);
      checks++;
      if (g !== 4'(1 << (k % 4)) || $countones(g) != 1 || eg != k % 4) begin
        errors++;
        $display("FAIL fair_grant_%0d: got grant=%b, want %b", k, g, 4'(1 << (k % 4)));
      end
      checks++;
      if (id !== 2'(eg) || p !== ref_prod(16'h5432, 16'h9631, eg) || !q) begin
        errors++;
        $display("FAIL fair_rsp_%0d: got id=%0d prod=%h, want %0d %h", k, id, p, eg,
                 ref_prod(16'h5432, 16'h9631, eg));
      end
      if (k > 0) begin
        checks++;
        if (gc - prev != 3) begin
          errors++;
          $display("FAIL fair_spacing_%0d: got %0d cycles, want 3", k, gc - prev);
        end
      end
      prev = gc;
      mptr = (eg + 1) % N;
    end
    req_valid = 4'd0;
  endtask

  task automatic test_backpressure();
    logic [3:0] g;
    int w, gc, lat, eg;
    logic [1:0] id;
    logic [7:0] p;
    logic q;
    eg = rr_pick(mptr, 4'b1000);
    issue(4'b1000, 16'hD000, 16'h7000, 5, g, w, gc, lat, id, p, q);
    mptr = (eg + 1) % N;
    checks++;
    if (g !== 4'b1000 || id !== 2'd3 || p !== 8'h5B || !q) begin
      errors++;
      $display("FAIL bp_hold: got grant=%b id=%0d prod=%h stable=%b, want 1000 3 5b 1",
               g, id, p, q);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rsp_valid=%b, want 0", rsp_valid);
    end
    // Back in IDLE right after the handshake: a waiting request is accepted at once.
    eg = rr_pick(mptr, 4'b0100);
    issue(4'b0100, 16'h0A00, 16'h0B00, 0, g, w, gc, lat, id, p, q);
    mptr = (eg + 1) % N;
    checks++;
    if (w != 0 || g !== 4'b0100 || p !== 8'h6E) begin
      errors++;
      $display("FAIL bp_next_idle: got wait=%0d grant=%b prod=%h, want 0 0100 6e", w, g, p);
    end
    req_valid = 4'd0;
  endtask

  task automatic test_reset_midop();
    logic [3:0] g;
    int w, gc, lat;
    logic [1:0] id;
    logic [7:0] p;
    logic q, silent;
    do_reset();
    // Reset during MUL.
    req_valid = 4'b0010;
    req_a     = 16'h00F0;
    req_b     = 16'h00F0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL midop_grant: got %b, want 0010", req_ready);
    end
    tick();
    rst       = 1'b1;
    req_valid = 4'd0;
    tick();
    rst    = 1'b0;
    silent = 1'b1;
    repeat (6) begin
      tick();
      if (rsp_valid !== 1'b0) silent = 1'b0;
    end
    checks++;
    if (!silent) begin
      errors++;
      $display("FAIL rst_in_mul: got a response after reset, want none");
    end
    // Reset during HOLD.
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = 4'd0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL midop_hold_reached: got rsp_valid=%b, want 1", rsp_valid);
    end
    rst       = 1'b1;
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'd0) begin
      errors++;
      $display("FAIL ready_in_reset: got %b, want 0000", req_ready);
    end
    tick();
    rst       = 1'b0;
    req_valid = 4'd0;
    silent    = (rsp_valid === 1'b0 && rsp_prod === 8'd0 && rsp_id === 2'd0);
    repeat (6) begin
      tick();
      if (rsp_valid !== 1'b0) silent = 1'b0;
    end
    checks++;
    if (!silent) begin
      errors++;
      $display("FAIL rst_in_hold: got valid=%b prod=%h, want no response", rsp_valid, rsp_prod);
    end
    mptr = 0;
    issue(4'b1100, 16'h7600, 16'h3200, 0, g, w, gc, lat, id, p, q);
    mptr = 3;
    checks++;
    if (g !== 4'b0100 || id !== 2'd2 || p !== 8'h0C) begin
      errors++;
      $display("FAIL post_rst_ptr: got grant=%b id=%0d prod=%h, want 0100 2 0c", g, id, p);
    end
    req_valid = 4'd0;
  endtask

  task automatic test_random_sweep();
    logic [3:0]  g, mask;
    logic [15:0] av, bv;
    logic [7:0]  pv, p;
    logic [1:0]  id;
    int w, gc, lat, eg, bad;
    logic q;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      pv   = 8'(k);
      mask = 4'($urandom_range(1, 15));
      eg   = rr_pick(mptr, mask);
      av   = 16'($urandom);
      bv   = 16'($urandom);
      av[4*eg +: 4] = pv[7:4];
      bv[4*eg +: 4] = pv[3:0];
      issue(mask, av, bv, $urandom_range(0, 2), g, w, gc, lat, id, p, q);
      mptr = (eg + 1) % N;
      checks++;
      if (g !== 4'(1 << eg) || id !== 2'(eg) || p !== 8'(int'(pv[7:4]) * int'(pv[3:0])) ||
          !q) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL sweep_%0d: got grant=%b id=%0d prod=%h, want %b %0d %h", k, g, id, p,
                   4'(1 << eg), eg, 8'(int'(pv[7:4]) * int'(pv[3:0])));
      end
    end
    req_valid = 4'd0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'd0;
    req_a     = 16'd0;
    req_b     = 16'd0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_corners();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    test_random_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
